mod15_count_checker: RTL and testbench
======================================

# mod15_count_checker

Cycle-accurate checker for the mod-15 up/down counter with load. It samples the same control inputs the counter sees (`rst`, `mode`, `load`, `data`) along with the counter's output. From these it predicts the next count, compares each observed count against the prediction and reports mismatches. It also reports terminal-count wrap events and keeps an error count plus a capture of the first failure. It sits beside the counter on the same clock and is used both in silicon self-check and in simulation.

## Interface
Parameters:
- `ERR_W`, 8: width of the saturating error counter.
- `HALT_ON_ERR`, 0: 1 means the first mismatch enters FAULT and stops comparisons until `clr_err` or `rst`; 0 means the checker keeps checking after a mismatch.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset. It is the same reset the counter receives.
- `en` in 1: checker enable.
- `mode` in 1: counter direction (1 = up, 0 = down), as driven to the counter.
- `load` in 1: counter load strobe, as driven to the counter.
- `data` in 4: counter load value.
- `count_in` in 4: the counter's `data_out`.
- `clr_err` in 1: clears the error state.
- `err_pulse` out 1: one-cycle pulse per mismatch.
- `fault` out 1: sticky; set on the first mismatch.
- `err_cnt` out ERR_W: saturating mismatch count.
- `exp_cap` out 4: expected value at the first mismatch.
- `act_cap` out 4: observed value at the first mismatch.
- `wrap_up` out 1: pulse for a predicted terminal wrap 14→0.
- `wrap_dn` out 1: pulse for a predicted decrement wrap 0→15.
- `state` out 2: 0 = IDLE, 1 = TRACK, 2 = FAULT.

## Operation
Reference next-state function `nxt(c)`, evaluated in priority order:
- `rst` gives 0.
- `load` gives `data`.
- `c==14` gives 0, regardless of `mode`.
- `mode=1` gives `c+1` modulo 16; 15 goes to 0.
- `mode=0` gives `c-1` modulo 16; 0 goes to 15.
- All arithmetic is 4-bit with natural wrap.

Model register `exp`:
- Every edge, `exp <= nxt(count_in)`.
- The prediction is always rebuilt from the observed value, so the model self-resyncs after any mismatch.
- `exp` updates in every state.

Compare:
- A compare happens at an edge where `state==TRACK`, `en=1`, `rst=0` and `clr_err=0`.
- Mismatch is `count_in != exp`.
- On mismatch:
  - `err_pulse <= 1`.
  - `err_cnt` increments, saturating at all-ones.
  - If `fault` was 0: `fault <= 1`, `exp_cap <= exp`, `act_cap <= count_in`.
- Later mismatches do not overwrite the capture.

State machine (priority `rst` > `clr_err` > others):
- IDLE → TRACK when `en=1`.
- TRACK → IDLE when `en=0`.
- TRACK → FAULT on mismatch, only when HALT_ON_ERR=1.
- FAULT → IDLE on `clr_err`. FAULT stays in FAULT otherwise, and `en` is ignored.
- `clr_err` in any state:
  - Clears `err_cnt`, `fault`, `exp_cap` and `act_cap`.
  - Suppresses the compare at that edge.
  - Sets the next state to IDLE.

Wrap flags:
- Registered at edges where `en=1`, `rst=0` and `load=0`.
- `wrap_up <= (count_in==14)`.
- `wrap_dn <= (count_in==0 && mode==0)`.
- The flags are active in any non-reset state.

## Timing
- Reset values (edge with `rst=1`): `state`=IDLE, `exp`=0, `err_pulse`=0, `fault`=0, `err_cnt`=0, `exp_cap`=0, `act_cap`=0, `wrap_up`=0, `wrap_dn`=0.
- All outputs are registered, with one-cycle latency. A mismatch present in cycle k (between edges k and k+1) shows `err_pulse` and updated counters in cycle k+1.
- After reset with `en=1`:
  - The first edge enters TRACK.
  - The first compare is at the second edge after reset deassertion.
- `rst` mid-operation:
  - Clears everything, including a sticky fault.
  - The counter and `exp` both restart at 0.
- A `load` coincident with `count_in==14` gives load priority: `exp=data` and no `wrap_up`.
- Load of 15:
  - Up direction: next is 0 with no `wrap_up`.
  - Down direction: next is 14.
- `en` toggling does not disturb `exp`. On re-entry to TRACK, compares are valid immediately.
- At saturation, `err_cnt` holds its value while `err_pulse` continues to pulse.

## Test plan
- Up count: `rst`, then `en=1`, `mode=1`, ideal counter running 40 cycles.
  - Required: `err_pulse` never asserted.
  - Required: `wrap_up` pulses once per 15 cycles, in the cycle the counter shows 0.
- Down count: from 0 with `mode=0`.
  - Required: expected sequence 15, 14, 13 …; `wrap_dn` pulses in the cycle the counter shows 15; no errors.
  - Required: in the step 14→0, a down count still goes to 0.
- Load: `load=1`, `data=9` while count=3, then `load=1`, `data=2` while count=14.
  - Required: `exp` values 9 and 2; no error; no `wrap_up`.
- Injected fault: force `count_in=7` where `exp=5`, with HALT_ON_ERR=0.
  - Required next cycle: `err_pulse=1`, `err_cnt=1`, `fault=1`, `exp_cap=5`, `act_cap=7`.
  - Required: the following correct cycles produce no further errors.
  - With HALT_ON_ERR=1: `state=FAULT` and no further compares until `clr_err`.
- Saturation: 300 consecutive mismatches with ERR_W=8.
  - Required: `err_cnt=255`; the capture holds the first mismatch.
  - Required: `clr_err` returns all fields to 0 and `state` to IDLE.
- Reset mid-stream: assert `rst` while `fault=1` and `err_cnt=4`.
  - Required: all outputs 0 and `state=IDLE`.
  - Required: compares resume at the second edge after `rst` deasserts.

Source files
------------

// File: rtl/mod15_count_checker_if.sv
// Control inputs and checker outputs bundled for the mod-15 counter checker.
// The master side drives the counter controls and observed count.
interface mod15_count_checker_if #(
   parameter int ERR_W = 8
);
   logic             en;
   logic             mode;
   logic             load;
   logic [3:0]       data;
   logic [3:0]       count_in;
   logic             clr_err;
   logic             err_pulse;
   logic             fault;
   logic [ERR_W-1:0] err_cnt;
   logic [3:0]       exp_cap;
   logic [3:0]       act_cap;
   logic             wrap_up;
   logic             wrap_dn;
   logic [1:0]       state;

   modport master (
      output en, mode, load, data, count_in, clr_err,
      input  err_pulse, fault, err_cnt, exp_cap, act_cap, wrap_up, wrap_dn, state
   );

   modport slave (
      input  en, mode, load, data, count_in, clr_err,
      output err_pulse, fault, err_cnt, exp_cap, act_cap, wrap_up, wrap_dn, state
   );
endinterface

// File: rtl/mod15_count_checker.sv
// Cycle-accurate checker for the mod-15 up/down counter with load: predicts the
// next count from the observed one, flags mismatches and terminal-count wraps.
//
// state | meaning
// IDLE  | checker disabled, prediction still tracks the counter
// TRACK | comparing observed count against prediction every edge
// FAULT | halted after a mismatch (HALT_ON_ERR=1) until clr_err or rst
module mod15_count_checker #(
   parameter int ERR_W       = 8,
   parameter int HALT_ON_ERR = 0
) (
   input logic                  clk,
   input logic                  rst,
   mod15_count_checker_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

   state_t           state_q, state_d;
   logic [3:0]       exp_q, exp_d;
   logic             err_pulse_q, err_pulse_d;
   logic             fault_q, fault_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [3:0]       exp_cap_q, exp_cap_d;
   logic [3:0]       act_cap_q, act_cap_d;
   logic             wrap_up_q, wrap_up_d;
   logic             wrap_dn_q, wrap_dn_d;
   logic             cmp_en;
   logic             mismatch;

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      err_pulse_d = 1'b0;
      fault_d     = fault_q;
      err_cnt_d   = err_cnt_q;
      exp_cap_d   = exp_cap_q;
      act_cap_d   = act_cap_q;
      wrap_up_d   = 1'b0;
      wrap_dn_d   = 1'b0;

      // Prediction is rebuilt from the observed count so the model resyncs after a miss.
      if (bus.load)
         exp_d = bus.data;
      else if (bus.count_in == 4'd14)
         exp_d = 4'd0;
      else if (bus.mode)
         exp_d = bus.count_in + 4'd1;
      else
         exp_d = bus.count_in - 4'd1;

      cmp_en   = (state_q == TRACK) && bus.en && !bus.clr_err;
      mismatch = cmp_en && (bus.count_in != exp_q);

      if (bus.en && !bus.load) begin
         wrap_up_d = (bus.count_in == 4'd14);
         wrap_dn_d = (bus.count_in == 4'd0) && !bus.mode;
      end

      if (bus.clr_err) begin
         state_d   = IDLE;
         fault_d   = 1'b0;
         err_cnt_d = '0;
         exp_cap_d = 4'd0;
         act_cap_d = 4'd0;
      end else begin
         if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1)
               err_cnt_d = err_cnt_q + ERR_ONE;
            if (!fault_q) begin
               fault_d   = 1'b1;
               exp_cap_d = exp_q;
               act_cap_d = bus.count_in;
            end
         end

         case (state_q)
            IDLE:    if (bus.en) state_d = TRACK;
            TRACK: begin
               if (!bus.en)
                  state_d = IDLE;
               else if (mismatch && (HALT_ON_ERR != 0))
                  state_d = FAULT;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         exp_q       <= 4'd0;
         err_pulse_q <= 1'b0;
         fault_q     <= 1'b0;
         err_cnt_q   <= '0;
         exp_cap_q   <= 4'd0;
         act_cap_q   <= 4'd0;
         wrap_up_q   <= 1'b0;
         wrap_dn_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         err_pulse_q <= err_pulse_d;
         fault_q     <= fault_d;
         err_cnt_q   <= err_cnt_d;
         exp_cap_q   <= exp_cap_d;
         act_cap_q   <= act_cap_d;
         wrap_up_q   <= wrap_up_d;
         wrap_dn_q   <= wrap_dn_d;
      end
   end

   assign bus.err_pulse = err_pulse_q;
   assign bus.fault     = fault_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.exp_cap   = exp_cap_q;
   assign bus.act_cap   = act_cap_q;
   assign bus.wrap_up   = wrap_up_q;
   assign bus.wrap_dn   = wrap_dn_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_mod15_count_checker.sv
// Directed bench for mod15_count_checker: an ideal counter feeds two checkers
// (continue-on-error and halt-on-error), compared every cycle against a model.
module tb_mod15_count_checker;
   localparam int ERR_W   = 8;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic       clk = 1'b0;
   logic       rst, en, mode, load, clr;
   logic [3:0] data, ctr;

   always #5 clk = ~clk;

   mod15_count_checker_if #(.ERR_W(ERR_W)) if0 ();
   mod15_count_checker_if #(.ERR_W(ERR_W)) if1 ();

   assign if0.en = en;   assign if0.mode = mode;   assign if0.load = load;
   assign if0.data = data; assign if0.count_in = ctr; assign if0.clr_err = clr;
   assign if1.en = en;   assign if1.mode = mode;   assign if1.load = load;
   assign if1.data = data; assign if1.count_in = ctr; assign if1.clr_err = clr;

   mod15_count_checker #(.ERR_W(ERR_W), .HALT_ON_ERR(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   mod15_count_checker #(.ERR_W(ERR_W), .HALT_ON_ERR(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference counter step, straight from the priority rules.
   function automatic logic [3:0] nxt(input logic r, input logic l, input logic [3:0] d,
                                      input logic m, input logic [3:0] c);
      int v;
      if (r) return 4'd0;
      if (l) return d;
      if (c == 4'd14) return 4'd0;
      v = m ? (int'(c) + 1) % 16 : (int'(c) + 15) % 16;
      return 4'(v);
   endfunction

   // Behavioural model: one entry per checker instance (0: continue, 1: halt).
   int m_exp[2], m_state[2], m_pulse[2], m_fault[2], m_cnt[2];
   int m_ecap[2], m_acap[2], m_wu[2], m_wd[2];
   bit m_valid = 1'b0;
   bit m_mis;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_mis = (m_state[i] == 1) && en && !rst && !clr && (int'(ctr) != m_exp[i]);
         if (rst) begin
            m_state[i] = 0; m_pulse[i] = 0; m_fault[i] = 0; m_cnt[i] = 0;
            m_ecap[i] = 0;  m_acap[i] = 0;  m_wu[i] = 0;    m_wd[i] = 0;
         end else begin
            if (clr) begin
               m_state[i] = 0; m_fault[i] = 0; m_cnt[i] = 0; m_ecap[i] = 0; m_acap[i] = 0;
            end else begin
               if (m_mis) begin
                  if (m_cnt[i] < ERR_MAX) m_cnt[i] = m_cnt[i] + 1;
                  if (m_fault[i] == 0) begin
                     m_fault[i] = 1; m_ecap[i] = m_exp[i]; m_acap[i] = int'(ctr);
                  end
               end
               if (m_state[i] == 0 && en) m_state[i] = 1;
               else if (m_state[i] == 1 && !en) m_state[i] = 0;
               else if (m_state[i] == 1 && m_mis && i == 1) m_state[i] = 2;
            end
            m_pulse[i] = int'(m_mis);
            m_wu[i] = int'(en && !load && ctr == 4'd14);
            m_wd[i] = int'(en && !load && ctr == 4'd0 && !mode);
         end
         m_exp[i] = int'(nxt(rst, load, data, mode, ctr));
      end
      if (rst) m_valid = 1'b1;
   end

   task automatic cmp_inst(input int i, input logic [1:0] st, input logic ep, input logic fl,
                           input logic [ERR_W-1:0] ec, input logic [3:0] xc, input logic [3:0] ac,
                           input logic wu, input logic wd);
      chk($sformatf("d%0d_state", i),     int'(st), m_state[i]);
      chk($sformatf("d%0d_err_pulse", i), int'(ep), m_pulse[i]);
      chk($sformatf("d%0d_fault", i),     int'(fl), m_fault[i]);
      chk($sformatf("d%0d_err_cnt", i),   int'(ec), m_cnt[i]);
      chk($sformatf("d%0d_exp_cap", i),   int'(xc), m_ecap[i]);
      chk($sformatf("d%0d_act_cap", i),   int'(ac), m_acap[i]);
      chk($sformatf("d%0d_wrap_up", i),   int'(wu), m_wu[i]);
      chk($sformatf("d%0d_wrap_dn", i),   int'(wd), m_wd[i]);
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         cmp_inst(0, if0.state, if0.err_pulse, if0.fault, if0.err_cnt, if0.exp_cap, if0.act_cap,
                  if0.wrap_up, if0.wrap_dn);
         cmp_inst(1, if1.state, if1.err_pulse, if1.fault, if1.err_cnt, if1.exp_cap, if1.act_cap,
                  if1.wrap_up, if1.wrap_dn);
      end
   end

   // Ideal counter advances with the same controls; tick_force models a glitched counter.
   task automatic tick();
      logic [3:0] n;
      n = nxt(rst, load, data, mode, ctr);
      @(posedge clk); #1;
      ctr = n;
   endtask

   task automatic tick_force(input logic [3:0] v);
      @(posedge clk); #1;
      ctr = v;
   endtask

   int n_wu, n_wd, n_ep;

   task automatic run(input int n);
      n_wu = 0; n_wd = 0; n_ep = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         @(negedge clk);
         n_wu += int'(if0.wrap_up);
         n_wd += int'(if0.wrap_dn);
         n_ep += int'(if0.err_pulse);
      end
   endtask

   logic [3:0] first_exp, first_act, nv;

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b1; load = 1'b0; clr = 1'b0; data = 4'd0; ctr = 4'd0;
      tick(); tick();
      @(negedge clk);
      chk("rst_state", int'(if0.state), 0);
      chk("rst_err_cnt", int'(if0.err_cnt), 0);

      // Up count for 40 cycles: wraps after 15 and 30 steps.
      rst = 1'b0; en = 1'b1; mode = 1'b1;
      run(40);
      chk("up_wrap_up_pulses", n_wu, 2);
      chk("up_err_pulses", n_ep, 0);
      chk("up_state_track", int'(if0.state), 1);

      en = 1'b0; run(3);
      en = 1'b1; run(5);
      chk("reenable_err_pulses", n_ep, 0);

      // Down count from 0: 15, 14, then 14 still steps to 0.
      rst = 1'b1; tick(); rst = 1'b0; mode = 1'b0;
      run(6);
      chk("dn_wrap_dn_pulses", n_wd, 2);
      chk("dn_wrap_up_pulses", n_wu, 2);
      chk("dn_err_pulses", n_ep, 0);
      load = 1'b1; data = 4'd13; tick(); load = 1'b0;
      run(4);
      chk("dn_13_err_pulses", n_ep, 0);

      // Loads: 9 while count=3, 2 while count=14, then 15 in both directions.
      mode = 1'b1; load = 1'b1; data = 4'd3; tick();
      data = 4'd9; tick();
      load = 1'b0; run(1);
      chk("load9_err_pulse", n_ep, 0);
      load = 1'b1; data = 4'd14; tick();
      data = 4'd2; run(1);
      chk("load_at14_no_wrap_up", n_wu, 0);
      load = 1'b0; run(1);
      chk("load2_err_pulse", n_ep, 0);
      load = 1'b1; data = 4'd15; tick();
      load = 1'b0; run(1);
      chk("load15_up_no_wrap_up", n_wu, 0);
      run(1);
      chk("load15_up_err_pulse", n_ep, 0);
      mode = 1'b0; load = 1'b1; data = 4'd15; tick();
      load = 1'b0; run(1);
      chk("load15_dn_no_wrap_dn", n_wd, 0);
      run(1);
      chk("load15_dn_to14_wrap_up", n_wu, 1);
      chk("load15_dn_err_pulse", n_ep, 0);

      // Injected fault: observed 7 where 5 is predicted.
      mode = 1'b1; load = 1'b1; data = 4'd4; tick(); load = 1'b0;
      tick_force(4'd7);
      @(negedge clk);
      chk("inj_pre_err_pulse", int'(if0.err_pulse), 0);
      tick();
      @(negedge clk);
      chk("inj_err_pulse", int'(if0.err_pulse), 1);
      chk("inj_err_cnt", int'(if0.err_cnt), 1);
      chk("inj_fault", int'(if0.fault), 1);
      chk("inj_exp_cap", int'(if0.exp_cap), 5);
      chk("inj_act_cap", int'(if0.act_cap), 7);
      chk("inj_halt_state", int'(if1.state), 2);
      run(4);
      chk("inj_after_err_pulses", n_ep, 0);
      chk("inj_after_err_cnt", int'(if0.err_cnt), 1);
      chk("inj_halt_still_fault", int'(if1.state), 2);

      clr = 1'b1; tick(); clr = 1'b0;
      @(negedge clk);
      chk("clr_state", int'(if0.state), 0);
      chk("clr_err_cnt", int'(if0.err_cnt), 0);
      chk("clr_fault", int'(if0.fault), 0);
      chk("clr_caps", int'({if0.exp_cap, if0.act_cap}), 0);
      chk("clr_halt_state", int'(if1.state), 0);

      // Saturation: 300 consecutive mismatches.
      tick();
      for (int k = 0; k < 300; k++) begin
         nv = nxt(rst, load, data, mode, ctr);
         if (k == 0) begin first_exp = nv; first_act = nv ^ 4'h1; end
         tick_force(nv ^ 4'h1);
      end
      tick();
      @(negedge clk);
      chk("sat_err_cnt", int'(if0.err_cnt), ERR_MAX);
      chk("sat_exp_cap", int'(if0.exp_cap), int'(first_exp));
      chk("sat_act_cap", int'(if0.act_cap), int'(first_act));
      chk("sat_halt_err_cnt", int'(if1.err_cnt), 1);
      clr = 1'b1; tick(); clr = 1'b0;
      @(negedge clk);
      chk("sat_clr_err_cnt", int'(if0.err_cnt), 0);
      chk("sat_clr_fault", int'(if0.fault), 0);
      chk("sat_clr_caps", int'({if0.exp_cap, if0.act_cap}), 0);
      chk("sat_clr_state", int'(if0.state), 0);

      // Reset mid-stream with fault set and err_cnt=4.
      tick();
      for (int k = 0; k < 4; k++) begin
         nv = nxt(rst, load, data, mode, ctr);
         tick_force(nv ^ 4'h2);
      end
      tick();
      @(negedge clk);
      chk("mid_err_cnt", int'(if0.err_cnt), 4);
      chk("mid_fault", int'(if0.fault), 1);
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_state", int'(if0.state), 0);
      chk("mid_rst_fault", int'(if0.fault), 0);
      chk("mid_rst_err_cnt", int'(if0.err_cnt), 0);
      chk("mid_rst_caps", int'({if0.exp_cap, if0.act_cap}), 0);
      ctr = 4'd5;
      tick_force(4'd9);
      @(negedge clk);
      chk("post_rst_edge1_no_cmp", int'(if0.err_pulse), 0);
      tick();
      @(negedge clk);
      chk("post_rst_edge2_cmp", int'(if0.err_pulse), 1);
      chk("post_rst_exp_cap", int'(if0.exp_cap), 6);
      chk("post_rst_act_cap", int'(if0.act_cap), 9);
      run(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
